// File: rtl/softmax_ctrl.sv
// Sequencer for the 8-lane float16 softmax datapath: LUT load, vector hold, divider tagging, 2-entry result FIFO.
// Optional SOFTMAX_CTRL_PERF_EN adds accepted-vector and stall counters.
module softmax_ctrl #(
    parameter int FLOAT_LEN = 16,
    parameter int MANT_LEN  = 10,
    parameter int LANES     = 8,
    parameter int LUT_DEPTH = 1024,
    parameter int SUM_LAT   = 4,
    parameter int DIV_LAT   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         lut_load_start,
    input  logic                         lut_in_valid,
    output logic                         lut_in_ready,
    input  logic [MANT_LEN-1:0]          lut_log2_data,
    input  logic [FLOAT_LEN-1:0]         lut_exp2_data,
    output logic                         lut_done,
    input  logic                         vec_in_valid,
    output logic                         vec_in_ready,
    input  logic [LANES*FLOAT_LEN-1:0]   vec_in_data,
    output logic [LANES*FLOAT_LEN-1:0]   dp_exp_in,
    output logic                         dp_lut_wr_en,
    output logic [MANT_LEN-1:0]          dp_log2_lut_data,
    output logic [FLOAT_LEN-1:0]         dp_exp2_lut_data,
    input  logic [LANES*FLOAT_LEN-1:0]   dp_softmax_out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*FLOAT_LEN-1:0]   out_data,
    output logic                         busy
`ifdef SOFTMAX_CTRL_PERF_EN
    ,
    output logic [31:0]                  perf_vec_count,
    output logic [31:0]                  perf_stall_count
`endif
);

    localparam int VEC_W  = LANES * FLOAT_LEN;
    localparam int CNT_W  = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1;
    localparam int HOLD_W = (SUM_LAT > 0) ? $clog2(SUM_LAT + 1) : 1;
    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(LUT_DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(SUM_LAT);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2,
        HOLD  = 2'd3
    } state_t;

    function automatic logic [7:0] count_tags(input logic [DIV_LAT-1:0] tags);
        logic [7:0] n;
        n = 8'd0;
        for (int i = 0; i < DIV_LAT; i++) begin
            n = n + {7'd0, tags[i]};
        end
        return n;
    endfunction

    state_t               state_r, state_next_s;
    logic [CNT_W-1:0]     word_cnt_r;
    logic                 lut_done_r;
    logic                 wr_en_r;
    logic [MANT_LEN-1:0]  log2_r;
    logic [FLOAT_LEN-1:0] exp2_r;
    logic [VEC_W-1:0]     hold_r;
    logic [HOLD_W-1:0]    hold_cnt_r;
    logic [DIV_LAT-1:0]   tag_r, tag_next_s;
    logic [VEC_W-1:0]     head_r, second_r;
    logic [1:0]           fifo_cnt_r, fifo_cnt_next_s;
    logic                 out_valid_r;
    logic                 busy_r;

    logic       lut_hs_s, last_word_s, hold_done_s, pop_s, push_s;
    logic       credit_ok_s, load_ok_s, start_load_s, vec_ready_s, vec_acc_s;
    logic [7:0] occupancy_s;

    // Handshake decode, credit accounting and next-state selection
    always_comb begin
        lut_hs_s        = (state_r == LOAD) && lut_in_valid;
        last_word_s     = lut_hs_s && (word_cnt_r == LAST_WORD);
        hold_done_s     = (state_r == HOLD) && (hold_cnt_r == {HOLD_W{1'b0}});
        pop_s           = out_valid_r && out_ready;
        push_s          = tag_r[DIV_LAT-1];
        // Vectors in hold, in the divider and in the FIFO, less the one leaving now
        occupancy_s     = {7'd0, (state_r == HOLD)} + count_tags(tag_r)
                        + {6'd0, fifo_cnt_r} - {7'd0, pop_s};
        credit_ok_s     = occupancy_s < 8'd2;
        load_ok_s       = (state_r == IDLE) ||
                          ((state_r == READY) && (tag_r == {DIV_LAT{1'b0}}) && (fifo_cnt_r == 2'd0));
        start_load_s    = lut_load_start && load_ok_s;
        vec_ready_s     = lut_done_r && credit_ok_s && !start_load_s &&
                          ((state_r == READY) || hold_done_s);
        vec_acc_s       = vec_in_valid && vec_ready_s;
        tag_next_s      = {tag_r[DIV_LAT-2:0], hold_done_s};
        fifo_cnt_next_s = fifo_cnt_r + {1'b0, push_s} - {1'b0, pop_s};
        state_next_s    = state_r;
        case (state_r)
            IDLE: begin
                if (start_load_s) state_next_s = LOAD;
                else              state_next_s = IDLE;
            end
            LOAD: begin
                if (last_word_s) state_next_s = READY;
                else             state_next_s = LOAD;
            end
            READY: begin
                if (start_load_s)   state_next_s = LOAD;
                else if (vec_acc_s) state_next_s = HOLD;
                else                state_next_s = READY;
            end
            HOLD: begin
                if (hold_done_s && !vec_acc_s) state_next_s = READY;
                else                           state_next_s = HOLD;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Control state, LUT write path, hold register and divider tags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            word_cnt_r <= {CNT_W{1'b0}};
            lut_done_r <= 1'b0;
            wr_en_r    <= 1'b0;
            log2_r     <= {MANT_LEN{1'b0}};
            exp2_r     <= {FLOAT_LEN{1'b0}};
            hold_r     <= {VEC_W{1'b0}};
            hold_cnt_r <= {HOLD_W{1'b0}};
            tag_r      <= {DIV_LAT{1'b0}};
            busy_r     <= 1'b0;
        end else begin
            state_r <= state_next_s;
            wr_en_r <= lut_hs_s;
            if (lut_hs_s) begin
                log2_r     <= lut_log2_data;
                exp2_r     <= lut_exp2_data;
                word_cnt_r <= word_cnt_r + CNT_ONE;
            end
            if (start_load_s) begin
                word_cnt_r <= {CNT_W{1'b0}};
                lut_done_r <= 1'b0;
            end else if (last_word_s) begin
                lut_done_r <= 1'b1;
            end
            if (vec_acc_s) begin
                hold_r     <= vec_in_data;
                hold_cnt_r <= HOLD_LOAD;
            end else if ((state_r == HOLD) && !hold_done_s) begin
                hold_cnt_r <= hold_cnt_r - HOLD_ONE;
            end
            tag_r  <= tag_next_s;
            busy_r <= (state_next_s == LOAD) || (state_next_s == HOLD) ||
                      (tag_next_s != {DIV_LAT{1'b0}}) || (fifo_cnt_next_s != 2'd0);
        end
    end

    // Two-entry result FIFO; head_r is always the oldest result
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r      <= {VEC_W{1'b0}};
            second_r    <= {VEC_W{1'b0}};
            fifo_cnt_r  <= 2'd0;
            out_valid_r <= 1'b0;
        end else begin
            if (push_s && pop_s) begin
                if (fifo_cnt_r == 2'd1) begin
                    head_r <= dp_softmax_out;
                end else begin
                    head_r   <= second_r;
                    second_r <= dp_softmax_out;
                end
            end else if (push_s) begin
                if (fifo_cnt_r == 2'd0) head_r <= dp_softmax_out;
                else                    second_r <= dp_softmax_out;
            end else if (pop_s) begin
                head_r <= second_r;
            end
            fifo_cnt_r  <= fifo_cnt_next_s;
            out_valid_r <= (fifo_cnt_next_s != 2'd0);
        end
    end

`ifdef SOFTMAX_CTRL_PERF_EN
    // Saturating accepted-vector and input-stall counters
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_vec_count   <= 32'd0;
            perf_stall_count <= 32'd0;
        end else begin
            if (vec_acc_s && (perf_vec_count != 32'hFFFF_FFFF))
                perf_vec_count <= perf_vec_count + 32'd1;
            if (vec_in_valid && !vec_ready_s && lut_done_r && (perf_stall_count != 32'hFFFF_FFFF))
                perf_stall_count <= perf_stall_count + 32'd1;
        end
    end
`endif

    assign lut_in_ready     = (state_r == LOAD);
    assign lut_done         = lut_done_r;
    assign vec_in_ready     = vec_ready_s;
    assign dp_exp_in        = hold_r;
    assign dp_lut_wr_en     = wr_en_r;
    assign dp_log2_lut_data = log2_r;
    assign dp_exp2_lut_data = exp2_r;
    assign out_valid        = out_valid_r;
    assign out_data         = head_r;
    assign busy             = busy_r;

endmodule

// File: tb/tb_softmax_ctrl.sv
// Self-checking bench for softmax_ctrl: queue-based reference model compared every cycle,
// plus directed literal checks of load count, latency, credit limit, spacing and reset.
module tb_softmax_ctrl;
    localparam int FL = 16, ML = 10, LN = 8, LD = 1024, SL = 4, DL = 4;
    localparam int VW = LN * FL;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, lut_load_start, lut_in_valid, lut_in_ready, lut_done;
    logic [ML-1:0] lut_log2_data, dp_log2_lut_data;
    logic [FL-1:0] lut_exp2_data, dp_exp2_lut_data;
    logic          vec_in_valid, vec_in_ready, dp_lut_wr_en, out_valid, out_ready, busy;
    logic [VW-1:0] vec_in_data, dp_exp_in, dp_softmax_out, out_data;

    softmax_ctrl #(.FLOAT_LEN(FL), .MANT_LEN(ML), .LANES(LN), .LUT_DEPTH(LD),
                   .SUM_LAT(SL), .DIV_LAT(DL)) dut (
        .clk(clk), .rst(rst), .lut_load_start(lut_load_start), .lut_in_valid(lut_in_valid),
        .lut_in_ready(lut_in_ready), .lut_log2_data(lut_log2_data), .lut_exp2_data(lut_exp2_data),
        .lut_done(lut_done), .vec_in_valid(vec_in_valid), .vec_in_ready(vec_in_ready),
        .vec_in_data(vec_in_data), .dp_exp_in(dp_exp_in), .dp_lut_wr_en(dp_lut_wr_en),
        .dp_log2_lut_data(dp_log2_lut_data), .dp_exp2_lut_data(dp_exp2_lut_data),
        .dp_softmax_out(dp_softmax_out), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy));

    int errors = 0, checks = 0, cyc = 0, wr_cnt = 0;
    bit armed = 1'b0;

    // Reference model state: loader progress, accepted vectors by due-push time, result FIFO
    bit            m_loading = 1'b0, m_done = 1'b0, m_wr_en = 1'b0, m_acc_now = 1'b0;
    int            m_words = 0, m_last_acc = -100, m_acc_total = 0;
    logic [ML-1:0] m_log2 = '0;
    logic [FL-1:0] m_exp2 = '0;
    logic [VW-1:0] m_last_vec = '0;
    int            m_push_t[$];
    logic [VW-1:0] m_fifo[$];
    logic [VW-1:0] hist [0:4095];

    task automatic chk(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic int pend();
        return m_push_t.size() + m_fifo.size();
    endfunction

    function automatic bit m_start_f();
        return lut_load_start && !m_loading && (!m_done || pend() == 0);
    endfunction

    function automatic bit m_ready_f();
        bit pop;
        pop = (m_fifo.size() != 0) && out_ready;
        return m_done && (cyc >= m_last_acc + SL + 1) && (pend() - int'(pop) < 2) && !m_start_f();
    endfunction

    task automatic model_step();
        bit pop, acc, hs, st;
        hist[cyc % 4096] = dp_softmax_out;
        if (rst) begin
            m_loading = 0; m_done = 0; m_wr_en = 0; m_words = 0; m_acc_now = 0;
            m_log2 = '0; m_exp2 = '0; m_last_vec = '0; m_last_acc = -100;
            m_push_t.delete(); m_fifo.delete();
            armed = 1'b1;
        end else begin
            pop = (m_fifo.size() != 0) && out_ready;
            acc = vec_in_valid && m_ready_f();
            st  = m_start_f();
            hs  = m_loading && lut_in_valid;
            m_wr_en = hs;
            if (hs) begin
                m_log2 = lut_log2_data; m_exp2 = lut_exp2_data; m_words++;
                if (m_words == LD) begin m_loading = 0; m_done = 1; end
            end
            if (st) begin m_loading = 1; m_done = 0; m_words = 0; end
            if (pop) void'(m_fifo.pop_front());
            if (m_push_t.size() != 0 && m_push_t[0] == cyc) begin
                m_fifo.push_back(dp_softmax_out);
                void'(m_push_t.pop_front());
            end
            m_acc_now = acc;
            if (acc) begin
                m_last_vec = vec_in_data; m_last_acc = cyc; m_acc_total++;
                m_push_t.push_back(cyc + SL + 1 + DL);
            end
        end
        cyc++;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Single compare process: every output against the model, away from the active edge
    initial forever begin
        @(negedge clk);
        if (armed) begin
            if (dp_lut_wr_en) wr_cnt++;
            chk("lut_in_ready", lut_in_ready, m_loading);
            chk("lut_done", lut_done, m_done);
            chk("vec_in_ready", vec_in_ready, m_ready_f());
            chk("dp_exp_in", dp_exp_in, m_last_vec);
            chk("dp_lut_wr_en", dp_lut_wr_en, m_wr_en);
            chk("dp_log2", dp_log2_lut_data, m_log2);
            chk("dp_exp2", dp_exp2_lut_data, m_exp2);
            chk("out_valid", out_valid, m_fifo.size() != 0);
            if (m_fifo.size() != 0) chk("out_data", out_data, m_fifo[0]);
            chk("busy", busy, m_loading || pend() != 0);
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        dp_softmax_out = {$urandom(), $urandom(), $urandom(), $urandom()};
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VW-1:0] rand_vec();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check_reset_vals();
        chk("rst_lut_in_ready", lut_in_ready, 0);
        chk("rst_lut_done", lut_done, 0);
        chk("rst_vec_in_ready", vec_in_ready, 0);
        chk("rst_dp_exp_in", dp_exp_in, 0);
        chk("rst_dp_lut_wr_en", dp_lut_wr_en, 0);
        chk("rst_dp_log2", dp_log2_lut_data, 0);
        chk("rst_dp_exp2", dp_exp2_lut_data, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
    endtask

    task automatic do_load(input bit gaps);
        int n;
        wr_cnt = 0;
        lut_load_start = 1'b1;
        tick();
        lut_load_start = 1'b0;
        n = 0;
        while (!m_done && n < 5000) begin
            lut_in_valid  = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            lut_log2_data = ML'($urandom());
            lut_exp2_data = FL'($urandom());
            tick();
            n++;
        end
        lut_in_valid = 1'b0;
        vec_in_valid = 1'b0;
        chk("load_lut_done", lut_done, 1);
        @(negedge clk);
        chk("load_wr_pulses", wr_cnt, LD);
    endtask

    initial begin
        int n, cnt, prev, acc_e;
        logic [VW-1:0] ones_vec;
        rst = 1'b1; lut_load_start = 1'b0; lut_in_valid = 1'b0; lut_log2_data = '0;
        lut_exp2_data = '0; vec_in_valid = 1'b0; vec_in_data = '0; out_ready = 1'b0;
        repeat (3) tick();
        check_reset_vals();
        rst = 1'b0;

        // Vectors offered before and during the first load must not be taken
        vec_in_valid = 1'b1;
        vec_in_data  = rand_vec();
        repeat (5) tick();
        do_load(1'b0);

        // Single vector of 1.0 in every lane
        ones_vec = {LN{16'h3C00}};
        out_ready = 1'b1; vec_in_data = ones_vec; vec_in_valid = 1'b1;
        n = 0;
        tick();
        while (!m_acc_now && n < 10) begin tick(); n++; end
        vec_in_valid = 1'b0;
        acc_e = m_last_acc;
        chk("single_dp_exp", dp_exp_in, ones_vec);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        chk("single_latency", cyc - acc_e, 10);
        chk("single_data", out_data, hist[(acc_e + 9) % 4096]);
        repeat (3) tick();

        // Backpressure: credit limit of two results
        out_ready = 1'b0; vec_in_valid = 1'b1; cnt = 0;
        repeat (30) begin
            vec_in_data = rand_vec();
            tick();
            if (m_acc_now) cnt++;
        end
        chk("bp_accepts", cnt, 2);
        chk("bp_ready_low", vec_in_ready, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        repeat (8) tick();
        vec_in_valid = 1'b0; out_ready = 1'b1;
        repeat (25) tick();

        // Back-to-back accepts without backpressure
        vec_in_valid = 1'b1; prev = -1;
        repeat (40) begin
            vec_in_data = rand_vec();
            tick();
            if (m_acc_now) begin
                if (prev >= 0) chk("b2b_spacing", m_last_acc - prev, 5);
                prev = m_last_acc;
            end
        end
        vec_in_valid = 1'b0;
        repeat (20) tick();

        // Load requests while a vector is held, then while a result waits
        vec_in_valid = 1'b1; vec_in_data = rand_vec(); n = 0;
        tick();
        while (!m_acc_now && n < 10) begin tick(); n++; end
        vec_in_valid = 1'b0;
        repeat (2) tick();
        lut_load_start = 1'b1;
        tick();
        lut_load_start = 1'b0;
        chk("hold_load_ignored", lut_done, 1);
        chk("hold_no_lut_ready", lut_in_ready, 0);
        out_ready = 1'b0;
        repeat (15) tick();
        lut_load_start = 1'b1;
        tick();
        lut_load_start = 1'b0;
        chk("pend_load_ignored", lut_done, 1);
        chk("pend_no_lut_ready", lut_in_ready, 0);
        chk("pend_out_valid", out_valid, 1);
        out_ready = 1'b1;
        repeat (5) tick();

        // Reset with two results in flight
        out_ready = 1'b0; vec_in_valid = 1'b1; cnt = 0; n = 0;
        while (cnt < 2 && n < 40) begin
            vec_in_data = rand_vec();
            tick();
            if (m_acc_now) cnt++;
            n++;
        end
        vec_in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check_reset_vals();
        rst = 1'b0; out_ready = 1'b1; vec_in_valid = 1'b1;
        repeat (20) tick();
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_vec_ready", vec_in_ready, 0);
        do_load(1'b1);

        // Randomized traffic
        repeat (3000) begin
            rst            = ($urandom_range(0, 999) == 0);
            lut_load_start = ($urandom_range(0, 399) == 0);
            lut_in_valid   = $urandom_range(0, 1) != 0;
            lut_log2_data  = ML'($urandom());
            lut_exp2_data  = FL'($urandom());
            vec_in_valid   = $urandom_range(0, 1) != 0;
            vec_in_data    = rand_vec();
            out_ready      = $urandom_range(0, 3) != 0;
            tick();
        end
        rst = 1'b0; lut_load_start = 1'b0; lut_in_valid = 1'b0; vec_in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (40) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/softmax_ctrl.md
# softmax_ctrl

Sequencer for the 8-lane float16 softmax datapath. Loads the shared log2/exp2 LUTs from a host stream, then accepts exponent vectors with a valid/ready handshake. Each vector is held stable on the datapath inputs until the adder-tree sum has settled, and is tagged into the divider pipeline. Results are captured into a 2-entry output FIFO with valid/ready backpressure. The block sits between the activation-accelerator top-level control and the softmax compute datapath.

## Interface
Parameters:
- FLOAT_LEN, 16, float16 word width
- MANT_LEN, 10, log2 LUT word width
- LANES, 8, vector lanes
- LUT_DEPTH, 1024, LUT writes per load (one write loads both LUTs)
- SUM_LAT, 4, cycles from stable datapath input to valid final sum
- DIV_LAT, 4, divider pipeline latency

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- lut_load_start  in  1  pulse: begin LUT load
- lut_in_valid  in  1  LUT word valid
- lut_in_ready  out  1  LUT word accepted
- lut_log2_data  in  MANT_LEN  log2 LUT word
- lut_exp2_data  in  FLOAT_LEN  exp2 LUT word
- lut_done  out  1  LUTs loaded, sticky
- vec_in_valid  in  1  input vector valid
- vec_in_ready  out  1  input vector accepted
- vec_in_data  in  LANES*FLOAT_LEN  exponents, lane 0 in LSBs
- dp_exp_in  out  LANES*FLOAT_LEN  to datapath exp inputs
- dp_lut_wr_en  out  1  to datapath LUT write enable
- dp_log2_lut_data  out  MANT_LEN  to datapath
- dp_exp2_lut_data  out  FLOAT_LEN  to datapath
- dp_softmax_out  in  LANES*FLOAT_LEN  from datapath results
- out_valid  out  1  result available
- out_ready  in  1  result consumed
- out_data  out  LANES*FLOAT_LEN  FIFO head
- busy  out  1  state ≠ IDLE/READY, or any vector in flight, or FIFO non-empty

## Operation
- States: IDLE, LOAD, READY, HOLD.
- IDLE → LOAD on lut_load_start.
- READY → LOAD on lut_load_start, but only if no vector is in flight and the FIFO is empty. Otherwise the pulse is ignored. lut_load_start in LOAD or HOLD is ignored.
- LOAD:
  - lut_in_ready=1.
  - Each lut_in_valid&&lut_in_ready drives dp_lut_wr_en=1 with the registered data the next cycle and increments a word counter (0..LUT_DEPTH-1).
  - Entering LOAD clears lut_done and the counter.
  - After the LUT_DEPTH-th word: lut_done=1, state → READY.
- READY:
  - vec_in_ready = lut_done && credit_ok.
  - credit_ok: (vectors in HOLD + tags in divider pipe + FIFO count − pop this cycle) < 2.
  - On accept: latch vec_in_data into the hold register, load the hold counter with SUM_LAT, state → HOLD.
- HOLD:
  - dp_exp_in = hold register; the counter decrements each cycle.
  - At counter==0, a valid tag enters a DIV_LAT-deep shift register.
  - On that same cycle, vec_in_ready may be asserted (subject to credit_ok) for a back-to-back accept, which reloads the counter and stays in HOLD. Otherwise → READY.
- dp_exp_in holds its last value outside HOLD.
- When a tag exits the shift register, dp_softmax_out is pushed into the FIFO. Credit accounting guarantees the FIFO is never full on a push.
- FIFO behaviour:
  - out_data is the head entry.
  - Pop on out_valid&&out_ready.
  - Simultaneous push and pop with count 2 cannot occur (credit). With count 1, the count stays 1.
- Reset, mid-operation:
  - State → IDLE; lut_done=0; tags, counters and FIFO cleared.
  - In-flight results are discarded. The datapath LUT contents are not erased, but lut_done=0 requires a reload.
- vec_in_valid with lut_done=0 is not accepted (vec_in_ready=0).

## Timing
- Reset values: lut_in_ready=0, lut_done=0, vec_in_ready=0, dp_exp_in=0, dp_lut_wr_en=0, dp_log2_lut_data=0, dp_exp2_lut_data=0, out_valid=0, out_data=0, busy=0.
- LUT write: dp_lut_wr_en is asserted 1 cycle after the handshake. lut_done rises 1 cycle after the final handshake.
- Vector accepted at edge T:
  - dp_exp_in is valid from T+1 for SUM_LAT+1 cycles.
  - Tag is inserted at T+1+SUM_LAT.
  - FIFO push at T+1+SUM_LAT+DIV_LAT.
  - out_valid at T+2+SUM_LAT+DIV_LAT, i.e. latency SUM_LAT+DIV_LAT+2 = 10 with defaults.
- Throughput: one vector per SUM_LAT+1 cycles when output is not backpressured.
- All outputs are registered except vec_in_ready and lut_in_ready.

## Configuration
- SOFTMAX_CTRL_PERF_EN defined: adds outputs perf_vec_count[31:0] (accepted vectors) and perf_stall_count[31:0] (cycles with vec_in_valid=1, vec_in_ready=0, lut_done=1). Both are cleared by rst, saturate at all-ones, and do not change functional timing.
- Macro not defined: ports and counters are absent.

## Test plan
- LUT_DEPTH words, each with lut_in_valid=1 → exactly LUT_DEPTH dp_lut_wr_en pulses carrying the data in order; lut_done=1 one cycle after the last handshake; vec_in_ready=0 before that point.
- Single vector accepted at T=100, all lanes 16'h3C00, out_ready=1 → dp_exp_in stable for cycles 101–105; out_valid=1 at cycle 110 with out_data = the dp_softmax_out sampled at cycle 109.
- Continuous vec_in_valid, out_ready=0 → exactly 2 vectors accepted; vec_in_ready stays 0 until out_ready pulses; FIFO order preserved.
- Back-to-back vectors with out_ready=1 → accepts spaced 5 cycles apart; each out_valid pulse carries the matching vector's result.
- lut_load_start during HOLD, and in READY with a result pending → ignored (state unchanged, lut_done stays 1).
- rst asserted for 1 cycle with 2 results in flight → all outputs return to reset values the next cycle; no stale out_valid afterwards; a reload is required before vec_in_ready=1.
